// File: rtl/serial_add32.sv
// -----------------------------------------------------------------------------
// serial_add32 -- nibble-serial 32-bit adder/subtractor
//
// Two 32-bit operands are captured on an accepted start. One 4-bit slice per
// cycle, LSB nibble first, goes through a single 4-bit carry look-ahead adder
// (cla4). The inter-nibble carry is held in a register. The 32-bit result is
// assembled by shifting each sum nibble in from the MSB end. Latency is
// 8 cycles from the accept edge to done.
//
// Ports
//   clk      in   1  rising-edge clock
//   reset    in   1  synchronous, active-high; has priority over start
//   start    in   1  request, sampled only while busy=0 (IDLE or DONE)
//   op       in   1  0 = a+b, 1 = a-b (captured with start)
//   a        in  32  operand A (captured with start)
//   b        in  32  operand B (captured with start)
//   result   out 32  sum/difference, valid from done until the next accept
//   co       out  1  carry out of bit 31 (subtract: 1 = no borrow)
//   ovf      out  1  two's-complement signed overflow
//   busy     out  1  high while nibbles are being processed
//   done     out  1  one-cycle pulse when result/co/ovf become valid
//   state_o  out  2  FSM state for observation: 0 IDLE, 1 CALC, 2 DONE
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0.
// The operands presented on that edge are the only ones used; start while
// busy=1 is dropped. Each accepted request yields exactly one done pulse
// unless reset intervenes.
// -----------------------------------------------------------------------------

module cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is expanded from generate/propagate and the carry-in,
    // rather than rippling through the lower carries.
    assign c[0] = ci_i;
    assign c[1] = g[0] | (p[0] & ci_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci_i);

    assign s_o  = p ^ c[3:0];
    assign co_o = c[4];
endmodule

module serial_add32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        co,
    output logic        ovf,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        c_q, c_d;
    logic [31:0] ra_q, ra_d;
    logic [31:0] rb_q, rb_d;
    logic [31:0] result_q, result_d;
    logic        co_q, co_d;
    logic        ovf_q, ovf_d;

    logic [3:0]  nib_s;
    logic        nib_co;

    cla4 u_cla4 (
        .a_i  (ra_q[3:0]),
        .b_i  (rb_q[3:0]),
        .ci_i (c_q),
        .s_o  (nib_s),
        .co_o (nib_co)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        result_d = result_q;
        co_d     = co_q;
        ovf_d    = ovf_q;

        case (state_q)
            CALC: begin
                c_d      = nib_co;
                result_d = {nib_s, result_q[31:4]};
                ra_d     = {4'b0000, ra_q[31:4]};
                rb_d     = {4'b0000, rb_q[31:4]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    co_d    = nib_co;
                    // rb_q holds the effective operand, already inverted for
                    // subtract, so the usual same-sign overflow rule applies.
                    ovf_d   = (ra_q[3] == rb_q[3]) && (nib_s[3] != ra_q[3]);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept from IDLE or DONE. Subtract is a + ~b + 1, with the +1
        // entering as the initial carry.
        if (start && (state_q != CALC)) begin
            state_d  = CALC;
            ra_d     = a;
            rb_d     = op ? ~b : b;
            c_d      = op;
            cnt_d    = 3'd0;
            result_d = 32'd0;
            co_d     = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            c_q      <= 1'b0;
            ra_q     <= 32'd0;
            rb_q     <= 32'd0;
            result_q <= 32'd0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            result_q <= result_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
        end
    end

    // busy/done are pure decodes of the state register, so neither has a
    // path from any input.
    assign result  = result_q;
    assign co      = co_q;
    assign ovf     = ovf_q;
    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign state_o = state_q;
endmodule

// File: tb/tb_serial_add32.sv
// -----------------------------------------------------------------------------
// tb_serial_add32 -- self-checking bench for serial_add32
// Table of operand/expected records plus hand-written control sequences.
// Expected {result, co, ovf} are pushed when a start is driven and popped when
// done is observed.
// -----------------------------------------------------------------------------

module tb_serial_add32;
    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        co;
    logic        ovf;
    logic        busy;
    logic        done;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    logic [33:0] exp_q[$];
    logic        prev_done;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        co;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    serial_add32 dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .result  (result),
        .co      (co),
        .ovf     (ovf),
        .busy    (busy),
        .done    (done),
        .state_o (state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [33:0] model(input logic m_op, input logic [31:0] ma,
                                          input logic [31:0] mb);
        logic [31:0] be;
        logic [32:0] s;
        logic        v;
        be = m_op ? ~mb : mb;
        s  = {1'b0, ma} + {1'b0, be} + {32'd0, m_op};
        v  = (ma[31] == be[31]) && (s[31] != ma[31]);
        return {s[31:0], s[32], v};
    endfunction

    // ---------------- scoreboard / protocol monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            prev_done <= 1'b0;
        end else begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap busy=%0b done=%0b required not both 1", busy, done);
            end
            checks++;
            if (done && prev_done) begin
                errors++;
                $display("FAIL done_two_cycles done high in consecutive cycles, required single pulse");
            end
            prev_done <= done;
            if (done) begin
                logic [33:0] e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done done=1 with no outstanding request");
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (result !== e[33:2]) begin
                        errors++;
                        $display("FAIL result got=%08h exp=%08h", result, e[33:2]);
                    end
                    checks++;
                    if (co !== e[1]) begin
                        errors++;
                        $display("FAIL co got=%0b exp=%0b (result exp=%08h)", co, e[1], e[33:2]);
                    end
                    checks++;
                    if (ovf !== e[0]) begin
                        errors++;
                        $display("FAIL ovf got=%0b exp=%0b (result exp=%08h)", ovf, e[0], e[33:2]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_start(input logic t_op, input logic [31:0] ta,
                               input logic [31:0] tb, input logic [33:0] e);
        start = 1'b1;
        op    = t_op;
        a     = ta;
        b     = tb;
        exp_q.push_back(e);
    endtask

    // Called #1 after an edge; counts edges until done is seen #1 after one.
    task automatic wait_done(input int exp_lat, input string name);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 30);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout no done within %0d cycles, required %0d", name, lat, exp_lat);
        end else if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency got=%0d cycles exp=%0d", name, lat, exp_lat);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (result !== 32'd0 || co !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL %s result=%08h co=%0b ovf=%0b busy=%0b done=%0b state=%0d required all 0",
                     name, result, co, ovf, busy, done, state_o);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        drive_start(v.op, v.a, v.b, {v.r, v.co, v.ovf});
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;   // later input changes must not disturb the run
        b     = $urandom;
        op    = $urandom_range(0, 1);
        wait_done(8, name);
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== v.r || co !== v.co || ovf !== v.ovf) begin
            errors++;
            $display("FAIL %s_hold done=%0b busy=%0b result=%08h co=%0b ovf=%0b exp result=%08h co=%0b ovf=%0b",
                     name, done, busy, result, co, ovf, v.r, v.co, v.ovf);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [33:0] m;
        vec_t v1;
        vec_t v2;

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        prev_done = 1'b0;

        vecs[0] = '{1'b0, 32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        for (int i = 6; i < 11; i++) begin
            vecs[i].op = $urandom_range(0, 1);
            vecs[i].a  = $urandom;
            vecs[i].b  = $urandom;
            m = model(vecs[i].op, vecs[i].a, vecs[i].b);
            vecs[i].r   = m[33:2];
            vecs[i].co  = m[1];
            vecs[i].ovf = m[0];
        end

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero("idle_after_reset");

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // start pulsed mid-run with a different pair must be ignored
        m = model(1'b0, 32'h12345678, 32'h11111111);
        drive_start(1'b0, 32'h12345678, 32'h11111111, m);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 1'b1;
        a     = 32'hDEADBEEF;
        b     = 32'h00000042;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(5, "ignored_start");
        repeat (3) @(posedge clk);
        #1;

        // start held through DONE: second run accepted with no IDLE cycle
        v1.op = 1'b0; v1.a = 32'h89ABCDEF; v1.b = 32'h76543211;
        m = model(v1.op, v1.a, v1.b);
        drive_start(v1.op, v1.a, v1.b, m);
        @(posedge clk);
        #1;
        wait_done(8, "b2b_first");
        v2.op = 1'b1; v2.a = 32'h00000100; v2.b = 32'h00000101;
        drive_start(v2.op, v2.a, v2.b, model(v2.op, v2.a, v2.b));
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept busy=%0b exp=1 right after DONE", busy);
        end
        wait_done(8, "b2b_second");
        repeat (2) @(posedge clk);
        #1;

        // reset at cycle 4 of a run
        drive_start(1'b0, 32'hFFFF0000, 32'h0000FFFF, model(1'b0, 32'hFFFF0000, 32'h0000FFFF));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;        // reset must win over start
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        exp_q.delete();
        check_zero("reset_midop");
        repeat (10) @(posedge clk);
        #1;
        check_zero("reset_no_resume");

        v1.op = 1'b1; v1.a = 32'h00000010; v1.b = 32'h00000001;
        v1.r = 32'h0000000F; v1.co = 1'b1; v1.ovf = 1'b0;
        run_vec(v1, "after_reset");

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL outstanding got=%0d results pending exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add32.md
# serial_add32

Nibble-serial 32-bit adder/subtractor built around one instance of the existing 4-bit carry look-ahead adder `cla4`. It sits directly upstream of `cla4` and sequences its operands. It captures two 32-bit operands on a start strobe and feeds one 4-bit slice per cycle, LSB nibble first, into `cla4`. It holds the inter-nibble carry in a register and assembles the 32-bit result plus flags. It trades 8 cycles of latency for a single 4-bit adder in the datapath.

## Interface
- No parameters. Width fixed at 32 bits (8 nibbles).
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request. Sampled only when `busy`=0.
- `op` in 1: 0 = add (a+b), 1 = subtract (a-b). Captured with `start`.
- `a` in 32: operand A. Captured with `start`.
- `b` in 32: operand B. Captured with `start`.
- `result` out 32: sum/difference. Valid while `done`=1 and held until the next accepted `start`.
- `co` out 1: carry out of bit 31. For subtract, 1 means no borrow.
- `ovf` out 1: two's-complement signed overflow.
- `busy` out 1: high while nibbles are being processed.
- `done` out 1: one-cycle pulse when `result`, `co` and `ovf` become valid.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: `busy`=1, nibble counter `cnt` runs 0..7.
  - DONE: `busy`=0, `done`=1 for exactly one cycle.
- Transitions:
  - IDLE→CALC on `start`=1.
  - CALC→CALC while `cnt`<7.
  - CALC→DONE after the edge that processes `cnt`=7.
  - DONE→CALC if `start`=1 in that cycle; otherwise DONE→IDLE.
- On accept:
  - Latch A into shift register `ra`.
  - Latch `op` ? ~b : b into shift register `rb`.
  - Load carry register `c` ← `op`.
  - Clear `cnt`.
  - Clear `result`, `co` and `ovf`.
- Each CALC cycle:
  - `cla4` computes `ra[3:0]`+`rb[3:0]`+`c`.
  - `c` ← cla4 `co`.
  - The 4-bit sum shifts into `result` from the MSB end (`result` ← {s, result[31:4]}).
  - `ra` and `rb` shift right by 4.
  - `cnt` increments.
- Final nibble (`cnt`=7):
  - `co` ← cla4 `co`.
  - `ovf` ← (`ra[3]` == `rb[3]`) && (s[3] != `ra[3]`). `rb` here is the effective (possibly inverted) operand.
- Arithmetic is modulo 2^32. There are no sign-extension or saturation rules.
- `start` while `busy`=1 is ignored. Operands captured on accept are unaffected by later input changes.
- `reset` asserted at any cycle, including mid-CALC:
  - Next state is IDLE.
  - `result`, `co`, `ovf`, `busy`, `done`, `cnt`, `c`, `ra` and `rb` all become 0.
  - `reset` has priority over `start`.

## Timing
- Reset values: `result`=0, `co`=0, `ovf`=0, `busy`=0, `done`=0.
- Let `start` be sampled at edge E0:
  - `busy`=1 from after E0 through edge E8.
  - Nibble k is processed at edge E(k+1).
  - `done`=1 and outputs valid after E8. `done` drops after E9 unless a new run completes.
- Latency from accepted `start` to `done` is 8 cycles. Back-to-back throughput is one result per 9 cycles: `start` held high during DONE gives E8 done, then E9 accept.
- `busy` and `done` are never high together. `done` never stays high for 2 consecutive cycles.
- `result`, `co` and `ovf` are stable from DONE until the next accept, or until `reset`.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- Add `0x0000000F` + `0x00000001`:
  - Required: `result`=`0x00000010`, `co`=0, `ovf`=0.
  - `done` exactly 8 cycles after `start`. Carry must ripple across the nibble boundary via `c`.
- Add `0xFFFFFFFF` + `0x00000001` → `result`=0, `co`=1, `ovf`=0.
- Add `0x7FFFFFFF` + `0x00000001` → `result`=`0x80000000`, `co`=0, `ovf`=1.
- Subtract, two cases:
  - `op`=1, 5 − 7 → `result`=`0xFFFFFFFE`, `co`=0, `ovf`=0.
  - `op`=1, `0x80000000` − 1 → `result`=`0x7FFFFFFF`, `co`=1, `ovf`=1.
- Control sequencing:
  - Pulse `start` with a second operand pair at cycle 3 of a run → ignored; first result unchanged.
  - Hold `start` high through DONE → new run accepted with no IDLE cycle.
- Reset mid-op:
  - Assert `reset` at cycle 4 of a run → next cycle all outputs 0 and IDLE.
  - A fresh `start` afterwards gives a correct result 8 cycles later.
